// File: rtl/sound_noise_gen.sv
`default_nettype none
// ============================================================================
// Module      : sound_noise_gen
// Description : APU noise channel built on one clock. It uses a prescaled
//               LFSR with a long or short (7-bit) mode, a length counter and a
//               volume envelope. The registered level goes to the APU mixer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk                  in  CPU clock, the only clock
//   rst                  in  synchronous reset, active-high
//   ce_length            in  256 Hz length tick strobe
//   ce_env               in  64 Hz envelope tick strobe
//   start                in  restart trigger
//   length               in  [LEN_W] initial length count
//   initial_volume       in  [VOL_W] envelope start volume
//   envelope_increasing  in  envelope direction (1 = up)
//   num_envelope_sweeps  in  [3] envelope period, 0 = frozen
//   shift_clock_freq     in  [4] LFSR step shift s
//   counter_width        in  0 = long LFSR, 1 = short LFSR
//   freq_dividing_ratio  in  [3] prescaler ratio r
//   single               in  1 = stop when the length counter expires
//   level                out [VOL_W] registered channel level
//   enable               out channel active
// Optional macro: SOUND_NOISE_DAC_GATE_EN. When this macro is defined, a
//   zero-volume decreasing configuration turns the channel off ("DAC off").
// ============================================================================
module sound_noise_gen #(
  parameter int LFSR_W    = 15,
  parameter int SHORT_TAP = 6,
  parameter int LEN_W     = 6,
  parameter int VOL_W     = 4,
  parameter int PRE_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce_length,
  input  logic             ce_env,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  input  logic [VOL_W-1:0] initial_volume,
  input  logic             envelope_increasing,
  input  logic [2:0]       num_envelope_sweeps,
  input  logic [3:0]       shift_clock_freq,
  input  logic             counter_width,
  input  logic [2:0]       freq_dividing_ratio,
  input  logic             single,
  output logic [VOL_W-1:0] level,
  output logic             enable
);

  localparam logic [VOL_W-1:0] c_vol_max = {VOL_W{1'b1}};
  localparam logic [LEN_W-1:0] c_len_max = {LEN_W{1'b1}};

  logic [2:0]        r_q, r_d;
  logic [3:0]        s_q, s_d;
  logic              short_q, short_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [13:0]       shift_q, shift_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [2:0]        env_q, env_d;
  logic [VOL_W-1:0]  vol_q, vol_d;
  logic              enable_q, enable_d;
  logic [VOL_W-1:0]  level_q, level_d;

  logic [LFSR_W-1:0] w_lfsr_step;
  logic              w_fb;
  logic [13:0]       w_shift_inc;
  logic [13:0]       w_shift_mask;
  logic              w_start_en;

  // Prescaler reload: 7 for r = 0, else 16*r - 1 (period 8 or 16*r clocks).
  function automatic logic [PRE_W-1:0] pre_reload(input logic [2:0] r);
    if (r == 3'd0) begin
      return PRE_W'(7);
    end
    return PRE_W'({r, 4'b0000} - 7'd1);
  endfunction

  // One LFSR step; short mode also writes the feedback into SHORT_TAP.
  always_comb begin
    w_fb        = lfsr_q[0] ^ lfsr_q[1];
    w_lfsr_step = {w_fb, lfsr_q[LFSR_W-1:1]};
    if (short_q) begin
      w_lfsr_step[SHORT_TAP] = w_fb;
    end
  end

  assign w_shift_inc  = shift_q + 14'd1;
  assign w_shift_mask = (14'd1 << s_q) - 14'd1;

`ifdef SOUND_NOISE_DAC_GATE_EN
  logic w_dac_off;
  assign w_dac_off  = (initial_volume == '0) && !envelope_increasing;
  assign w_start_en = !w_dac_off;
`else
  assign w_start_en = 1'b1;
`endif

  always_comb begin
    r_d      = r_q;
    s_d      = s_q;
    short_d  = short_q;
    lfsr_d   = lfsr_q;
    pre_d    = pre_q;
    shift_d  = shift_q;
    len_d    = len_q;
    env_d    = env_q;
    vol_d    = vol_q;
    enable_d = enable_q;
    level_d  = (enable_q && !lfsr_q[0]) ? vol_q : '0;

    if (start) begin
      r_d      = freq_dividing_ratio;
      s_d      = shift_clock_freq;
      short_d  = counter_width;
      lfsr_d   = '1;
      pre_d    = pre_reload(freq_dividing_ratio);
      shift_d  = '0;
      vol_d    = initial_volume;
      env_d    = num_envelope_sweeps;
      len_d    = length;
      enable_d = w_start_en;
    end else if (enable_q) begin
      // Prescaler tick advances the shift counter. The LFSR steps when the
      // low s bits of the counter wrap to zero. s >= 14 never steps.
      if (pre_q == '0) begin
        pre_d   = pre_reload(r_q);
        shift_d = w_shift_inc;
        if ((s_q < 4'd14) && ((w_shift_inc & w_shift_mask) == 14'd0)) begin
          lfsr_d = w_lfsr_step;
        end
      end else begin
        pre_d = pre_q - PRE_W'(1);
      end

      // Envelope: timer counts n strobes, then the volume moves one step
      // and saturates at either end.
      if (ce_env && (num_envelope_sweeps != 3'd0)) begin
        if (env_q <= 3'd1) begin
          env_d = num_envelope_sweeps;
          if (envelope_increasing) begin
            if (vol_q != c_vol_max) vol_d = vol_q + VOL_W'(1);
          end else begin
            if (vol_q != '0) vol_d = vol_q - VOL_W'(1);
          end
        end else begin
          env_d = env_q - 3'd1;
        end
      end

      // Length counts up; wrapping past all-ones ends the note.
      if (ce_length && single) begin
        len_d = len_q + LEN_W'(1);
        if (len_q == c_len_max) begin
          enable_d = 1'b0;
        end
      end

`ifdef SOUND_NOISE_DAC_GATE_EN
      if (w_dac_off) begin
        enable_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q      <= '0;
      s_q      <= '0;
      short_q  <= 1'b0;
      lfsr_q   <= '1;
      pre_q    <= '0;
      shift_q  <= '0;
      len_q    <= '0;
      env_q    <= '0;
      vol_q    <= '0;
      enable_q <= 1'b0;
      level_q  <= '0;
    end else begin
      r_q      <= r_d;
      s_q      <= s_d;
      short_q  <= short_d;
      lfsr_q   <= lfsr_d;
      pre_q    <= pre_d;
      shift_q  <= shift_d;
      len_q    <= len_d;
      env_q    <= env_d;
      vol_q    <= vol_d;
      enable_q <= enable_d;
      level_q  <= level_d;
    end
  end

  assign level  = level_q;
  assign enable = enable_q;

endmodule
`default_nettype wire

// File: doc/sound_noise_gen.md
Name: sound_noise_gen

Overview:
Fully synchronous, parametrised noise channel for the APU. It replaces derived-clock dividers with clock enables, runs on the single CPU clock, and adds selectable LFSR width with short-mode feedback into bit 6. It also integrates the length counter and volume envelope. Its output feeds the APU mixer alongside the square and wave channels.

Parameters:
LFSR_W, 15, long-mode LFSR width (>= 8)
SHORT_TAP, 6, bit index that also receives feedback in short mode
LEN_W, 6, length counter width
VOL_W, 4, volume/level width
PRE_W, 8, prescaler counter width (must hold 16*7-1)

Ports:
clk  in  1  CPU clock (4.19 MHz), the only clock
rst  in  1  synchronous reset, active-high
ce_length  in  1  one-cycle strobe, 256 Hz length tick
ce_env  in  1  one-cycle strobe, 64 Hz envelope tick
start  in  1  one-cycle trigger, restarts channel
length  in  LEN_W  initial length count t1
initial_volume  in  VOL_W  envelope start volume
envelope_increasing  in  1  1 = up, 0 = down
num_envelope_sweeps  in  3  envelope period n, 0 = frozen
shift_clock_freq  in  4  s
counter_width  in  1  0 = long LFSR, 1 = short (7-bit)
freq_dividing_ratio  in  3  r
single  in  1  1 = stop when length expires
level  out  VOL_W  registered channel level
enable  out  1  channel active

Behaviour:
- Reset: level = 0, enable = 0, lfsr = all ones, vol = 0, prescaler = 0, shift counter = 0, length counter = 0, envelope timer = 0.
- Priority in any cycle: rst > start > ce_length/ce_env/LFSR step.
- start:
  - Latch r, s and counter_width.
  - Load lfsr = all ones, prescaler = pre_reload, shift counter = 0.
  - Load vol = initial_volume, env timer = num_envelope_sweeps, length counter = length.
  - Set enable = 1.
- pre_reload = 7 when r = 0, else 16*r - 1.
- Prescaler:
  - Decrements each clk while enable = 1.
  - At 0 it reloads and emits a one-cycle tick.
- Shift counter (14 bits): increments on each tick. The LFSR steps on the tick where the counter's low s bits wrap to 0.
- Resulting step period: (r = 0 ? 8 : 16*r) << s clocks.
- s = 14 or 15: no LFSR steps at all; level holds its current value.
- LFSR step:
  - x = lfsr[0] ^ lfsr[1]; lfsr = {x, lfsr[LFSR_W-1:1]}.
  - Short mode: also lfsr[SHORT_TAP] = x after the shift. Upper bits keep shifting and are not cleared.
- Length:
  - On ce_length with single = 1 and enable = 1, the length counter increments.
  - Wrap from 2^LEN_W - 1 to 0 clears enable in that same cycle.
  - single = 0: counter is frozen, channel never expires.
- Envelope:
  - On ce_env with n != 0 and enable = 1, the timer decrements.
  - On reaching 0 the timer reloads n and vol steps by +/-1.
  - vol saturates at 0 and at 2^VOL_W - 1; no wrap.
  - n = 0: vol is frozen.
- Output: level <= (enable & ~lfsr[0]) ? vol : 0, registered, so there is 1 cycle of latency from the lfsr/vol change.
- Disabled channel: prescaler and LFSR are frozen, level = 0 by the next cycle.
- start while running: a full restart per the list above, with no glitch beyond the 1-cycle registered update.
- rst mid-operation: returns to reset values on the next edge.

Optional Feature:
Macro SOUND_NOISE_DAC_GATE_EN.
- Defined: start with initial_volume = 0 and envelope_increasing = 0 leaves enable = 0 ("DAC off"). Writing such a config while running also clears enable in the next cycle.
- Undefined: start always sets enable = 1; a zero-volume channel stays enabled and outputs 0.

Test Plan:
- rst, then start with r = 0, s = 0, long mode, vol 15, n = 0 -> LFSR steps every 8 clk; level = 0 for steps 1-14, level = 15 one cycle after step 15.
- Same with counter_width = 1 -> level = 15 one cycle after step 7. lfsr[6] tracks bit 14 feedback.
- r = 1, s = 2 -> step spacing exactly 64 clk. s = 14 -> no steps over 100000 clk.
- length = 62, single = 1, then 2 ce_length strobes -> enable falls on the 2nd strobe and level = 0 next cycle. single = 0 -> enable stays 1 after 100 strobes.
- vol = 15, decreasing, n = 1 -> 15 ce_env strobes bring vol to 0, and a 16th keeps it 0. Increasing from 14 with n = 2 -> 15 after 2 strobes, saturates.
- start and ce_length in the same cycle -> length counter = length (start wins).
- With SOUND_NOISE_DAC_GATE_EN, start with vol 0 decreasing -> enable stays 0.
